// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder: two-stage valid/ready pipeline that packs
// field bundles into 32-bit words and tags each word with a wrapping address.
module instr_encoder #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        func3,
    input  logic [6:0]        func7,
    input  logic [4:0]        r1,
    input  logic [4:0]        r2,
    input  logic [4:0]        rd,
    input  logic [20:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] out_addr,
    output logic              illegal,
    output logic [7:0]        illegal_cnt
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic        s1_valid;
    logic [6:0]  s1_opcode;
    logic [2:0]  s1_func3;
    logic [6:0]  s1_func7;
    logic [4:0]  s1_r1;
    logic [4:0]  s1_r2;
    logic [4:0]  s1_rd;
    logic [20:0] s1_imm;

    logic        accept;
    logic        s2_load;
    logic        handshake;
    logic [31:0] enc_word;
    logic        enc_illegal;

    assign in_ready  = !s1_valid || !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign s2_load   = s1_valid && (!out_valid || out_ready);
    assign handshake = out_valid && out_ready;

    // Field packing by instruction format; unknown opcodes become a flagged nop
    always_comb begin
        enc_word    = NOP_WORD;
        enc_illegal = 1'b0;
        case (s1_opcode)
            OP_R:
                enc_word = {s1_func7, s1_r2, s1_r1, s1_func3, s1_rd, s1_opcode};
            OP_IMM, OP_LOAD, OP_JALR:
                enc_word = {s1_imm[11:0], s1_r1, s1_func3, s1_rd, s1_opcode};
            OP_STORE:
                enc_word = {s1_imm[11:5], s1_r2, s1_r1, s1_func3, s1_imm[4:0], s1_opcode};
            OP_BRANCH:
                enc_word = {s1_imm[12], s1_imm[10:5], s1_r2, s1_r1, s1_func3,
                            s1_imm[4:1], s1_imm[11], s1_opcode};
            OP_LUI, OP_AUIPC:
                enc_word = {s1_imm[19:0], s1_rd, s1_opcode};
            OP_JAL:
                enc_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                            s1_rd, s1_opcode};
            default: begin
                enc_word    = NOP_WORD;
                enc_illegal = 1'b1;
            end
        endcase
    end

    // Input stage: captures a bundle on accept, empties when it moves to S2
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_opcode <= '0;
            s1_func3  <= '0;
            s1_func7  <= '0;
            s1_r1     <= '0;
            s1_r2     <= '0;
            s1_rd     <= '0;
            s1_imm    <= '0;
        end else if (accept) begin
            s1_valid  <= 1'b1;
            s1_opcode <= opcode;
            s1_func3  <= func3;
            s1_func7  <= func7;
            s1_r1     <= r1;
            s1_r2     <= r2;
            s1_rd     <= rd;
            s1_imm    <= imm;
        end else if (s2_load) begin
            s1_valid  <= 1'b0;
        end
    end

    // Output stage: holds the word steady while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            instruction <= '0;
            illegal     <= 1'b0;
        end else if (s2_load) begin
            out_valid   <= 1'b1;
            instruction <= enc_word;
            illegal     <= enc_illegal;
        end else if (handshake) begin
            out_valid   <= 1'b0;
        end
    end

    // Word address and illegal-word tally advance only on an output handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            out_addr    <= ADDR_W'(BASE_ADDR);
            illegal_cnt <= '0;
        end else if (handshake) begin
            out_addr <= out_addr + ADDR_W'(1);
            if (illegal && (illegal_cnt != CNT_MAX)) begin
                illegal_cnt <= illegal_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: vector table through a scoreboard plus
// hand-written latency, stall, saturation and mid-flight reset sequences.
module tb_instr_encoder;

    localparam int NV = 17;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  rd;
        logic [20:0] imm;
        logic [31:0] exp;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  rd;
    logic [20:0] imm;

    logic        in_ready,  in_ready2;
    logic        out_valid, out_valid2;
    logic [31:0] instruction, instruction2;
    logic [7:0]  out_addr;
    logic [1:0]  out_addr2;
    logic        illegal, illegal2;
    logic [7:0]  illegal_cnt, illegal_cnt2;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [31:0] cur_exp;
    logic        cur_ill;
    logic [31:0] exp_q[$];
    logic        exp_ill_q[$];
    int          hs_cyc_q[$];
    logic [7:0]  exp_addr = 8'd0;

    vec_t vecs[NV];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instr_encoder u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .func3(func3), .func7(func7), .r1(r1), .r2(r2),
        .rd(rd), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .instruction(instruction), .out_addr(out_addr), .illegal(illegal),
        .illegal_cnt(illegal_cnt)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .opcode(opcode), .func3(func3), .func7(func7), .r1(r1), .r2(r2),
        .rd(rd), .imm(imm), .out_valid(out_valid2), .out_ready(out_ready),
        .instruction(instruction2), .out_addr(out_addr2), .illegal(illegal2),
        .illegal_cnt(illegal_cnt2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [4:0] a1,
                                input logic [4:0] a2, input logic [4:0] ad,
                                input logic [20:0] im, input logic [31:0] ex,
                                input logic il);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.r1 = a1; v.r2 = a2; v.rd = ad;
        v.imm = im; v.exp = ex; v.ill = il;
        return v;
    endfunction

    // Scoreboard: expectations pushed on accept, checked in order on handshake
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_ill_q.delete();
            exp_addr = 8'd0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got 0x%08h, expected no word", instruction);
                end else begin
                    logic [31:0] e;
                    logic        ei;
                    e  = exp_q.pop_front();
                    ei = exp_ill_q.pop_front();
                    chk("instruction", instruction, e);
                    chk("illegal", 32'(illegal), 32'(ei));
                    chk("out_addr", 32'(out_addr), 32'(exp_addr));
                    chk("instruction_w2", instruction2, e);
                    chk("illegal_w2", 32'(illegal2), 32'(ei));
                    chk("out_valid_w2", 32'(out_valid2), 32'd1);
                    chk("out_addr_w2", 32'(out_addr2), 32'(exp_addr[1:0]));
                    exp_addr = exp_addr + 8'd1;
                    hs_cyc_q.push_back(cyc);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(cur_exp);
                exp_ill_q.push_back(cur_ill);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input vec_t v);
        opcode = v.op; func3 = v.f3; func7 = v.f7;
        r1 = v.r1; r2 = v.r2; rd = v.rd; imm = v.imm;
        cur_exp = v.exp; cur_ill = v.ill;
    endtask

    task automatic send(input vec_t v, input bit must_be_ready);
        set_vec(v);
        in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (must_be_ready && k == 0) begin
                chk("in_ready_b2b", 32'(in_ready), 32'd1);
                chk("in_ready_b2b_w2", 32'(in_ready2), 32'd1);
            end
            if (in_ready) begin
                step();
                in_valid = 1'b0;
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL send_timeout: got in_ready=0 for 100 clk, expected accept");
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 400; k++) begin
            if (exp_q.size() == 0 && !out_valid) return;
            step();
        end
        tests++;
        fails++;
        $display("FAIL drain_timeout: got %0d words pending, expected 0", exp_q.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int acc;
        int idx;
        bool_loop: begin end

        vecs[0]  = mk(7'h33, 3'd0, 7'h00, 5'd1, 5'd2,  5'd1,  21'd0,       32'h002080B3, 1'b0);
        vecs[1]  = mk(7'h63, 3'd0, 7'h00, 5'd1, 5'd2,  5'd0,  21'd2048,    32'h002080E3, 1'b0);
        vecs[2]  = mk(7'h6F, 3'd0, 7'h00, 5'd0, 5'd0,  5'd1,  21'd2048,    32'h001000EF, 1'b0);
        vecs[3]  = mk(7'h6F, 3'd0, 7'h00, 5'd0, 5'd0,  5'd1,  21'h080000,  32'h000800EF, 1'b0);
        vecs[4]  = mk(7'h7F, 3'd5, 7'h2A, 5'd3, 5'd4,  5'd5,  21'h012345,  32'h00000013, 1'b1);
        vecs[5]  = mk(7'h13, 3'd0, 7'h7F, 5'd6, 5'h1F, 5'd5,  21'h1FF7FF,  32'h7FF30293, 1'b0);
        vecs[6]  = mk(7'h23, 3'd2, 7'h00, 5'd2, 5'd3,  5'h1F, 21'h000FFC,  32'hFE312E23, 1'b0);
        vecs[7]  = mk(7'h37, 3'd0, 7'h00, 5'd0, 5'd0,  5'd10, 21'h1ABCDE,  32'hABCDE537, 1'b0);
        vecs[8]  = mk(7'h17, 3'd0, 7'h00, 5'd0, 5'd0,  5'd1,  21'h012345,  32'h12345097, 1'b0);
        vecs[9]  = mk(7'h63, 3'd1, 7'h00, 5'd0, 5'd0,  5'd0,  21'h1FFFFC,  32'hFE001EE3, 1'b0);
        vecs[10] = mk(7'h6F, 3'd0, 7'h00, 5'd0, 5'd0,  5'd0,  21'h000001,  32'h0000006F, 1'b0);
        vecs[11] = mk(7'h6F, 3'd0, 7'h00, 5'd0, 5'd0,  5'd0,  21'h100000,  32'h8000006F, 1'b0);
        vecs[12] = mk(7'h03, 3'd2, 7'h00, 5'd2, 5'd0,  5'd1,  21'h1FFFFF,  32'hFFF12083, 1'b0);
        vecs[13] = mk(7'h67, 3'd0, 7'h00, 5'd1, 5'd0,  5'd0,  21'd0,       32'h00008067, 1'b0);
        vecs[14] = mk(7'h00, 3'd0, 7'h00, 5'd0, 5'd0,  5'd0,  21'd0,       32'h00000013, 1'b1);
        vecs[15] = mk(7'h33, 3'd0, 7'h20, 5'd2, 5'd3,  5'd1,  21'd0,       32'h403100B3, 1'b0);
        vecs[16] = mk(7'h73, 3'd0, 7'h00, 5'd0, 5'd0,  5'd0,  21'd0,       32'h00000013, 1'b1);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        set_vec(vecs[0]);
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_instruction", instruction, 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        chk("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_addr_w2", 32'(out_addr2), 32'd0);
        rst = 1'b0;

        // Latency: word appears two cycles after the accept cycle
        out_ready = 1'b1;
        set_vec(vecs[0]);
        in_valid = 1'b1;
        @(negedge clk);
        chk("lat_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("lat_stage1_only", 32'(out_valid), 32'd0);
        step();
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        chk("lat_instruction", instruction, 32'h002080B3);
        chk("lat_out_addr", 32'(out_addr), 32'd0);
        drain();

        // Full table back-to-back with a always-ready consumer
        base = hs_cyc_q.size();
        for (int i = 0; i < NV; i++) send(vecs[i], 1'b1);
        drain();
        chk("b2b_count", 32'(hs_cyc_q.size() - base), 32'(NV));
        for (int i = base + 1; i < hs_cyc_q.size(); i++)
            chk("b2b_gap", 32'(hs_cyc_q[i] - hs_cyc_q[i-1]), 32'd1);
        chk("illegal_cnt_3", 32'(illegal_cnt), 32'd3);
        chk("illegal_cnt_3_w2", 32'(illegal_cnt2), 32'd3);

        // Consumer stalls 5 clk while 3 bundles are offered
        out_ready = 1'b0;
        idx = 0;
        acc = 0;
        set_vec(vecs[5]);
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bit take;
            @(negedge clk);
            take = in_valid && in_ready;
            step();
            if (take) begin
                acc++;
                idx++;
                if (idx < 3) set_vec(vecs[5 + idx]);
                else in_valid = 1'b0;
            end
            if (c >= 1) begin
                chk("stall_out_valid", 32'(out_valid), 32'd1);
                chk("stall_instruction", instruction, vecs[5].exp);
                chk("stall_out_addr", 32'(out_addr), 32'(1 + NV));
            end
        end
        chk("stall_accepted", 32'(acc), 32'd2);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_in_ready_w2", 32'(in_ready2), 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 20 && in_valid; k++) begin
            @(negedge clk);
            if (in_ready) begin
                step();
                in_valid = 1'b0;
            end
        end
        chk("stall_third_accepted", 32'(in_valid), 32'd0);
        drain();

        // Saturation of the illegal-word counter
        for (int i = 0; i < 256; i++) send(vecs[4], 1'b1);
        drain();
        chk("illegal_cnt_sat", 32'(illegal_cnt), 32'd255);
        chk("illegal_cnt_sat_w2", 32'(illegal_cnt2), 32'd255);

        // Reset with both stages full discards everything
        out_ready = 1'b0;
        send(vecs[0], 1'b0);
        send(vecs[1], 1'b0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_instruction", instruction, 32'd0);
        chk("mrst_out_addr", 32'(out_addr), 32'd0);
        chk("mrst_illegal_cnt", 32'(illegal_cnt), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        chk("mrst_out_addr_w2", 32'(out_addr2), 32'd0);
        chk("mrst_illegal_cnt_w2", 32'(illegal_cnt2), 32'd0);
        step();
        step();
        chk("mrst_s1_discarded", 32'(out_valid), 32'd0);
        send(vecs[7], 1'b1);
        step();
        chk("post_rst_out_valid", 32'(out_valid), 32'd1);
        chk("post_rst_out_addr", 32'(out_addr), 32'd0);
        chk("post_rst_instruction", instruction, 32'hABCDE537);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
